clamp_spos_stream: RTL

CLAMP_SPOS_STREAM -- requirements
Module: clamp_spos_stream

---
 rtl/clamp_spos_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clamp_spos_stream.sv
// rtl/clamp_spos_stream.sv - two-stage signed-to-unsigned clamp/wrap stream with saturation counter
module clamp_spos_stream #(
  parameter int INW  = 16,
  parameter int OUTW = 8,
  parameter int NCH  = 3,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NCH*INW-1:0]   i_data,
  input  logic                 i_wrap,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NCH*OUTW-1:0]  o_data,
  output logic [NCH-1:0]       o_satMask,
  input  logic                 i_clrCnt,
  output logic [CNTW-1:0]      o_satCnt,
  output logic                 o_satSticky
);

  // Stage 1: raw low bits plus the two range indicators per channel.
  logic                s1_valid_q;
  logic                s1_wrap_q;
  logic [NCH*OUTW-1:0] s1_raw_q;
  logic [NCH-1:0]      s1_neg_q;
  logic [NCH-1:0]      s1_ovf_q;

  logic [NCH*OUTW-1:0] s1_raw_d;
  logic [NCH-1:0]      s1_neg_d;
  logic [NCH-1:0]      s1_ovf_d;

  // Stage 2: final per-channel result and modified-mask, driven straight to the outputs.
  logic                s2_valid_q;
  logic [NCH*OUTW-1:0] s2_data_q;
  logic [NCH-1:0]      s2_mask_q;

  logic [NCH*OUTW-1:0] s2_data_d;
  logic [NCH-1:0]      s2_mask_d;

  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                sticky_q, sticky_d;

  logic                adv;
  logic                sat_xfer;

  // Both stages move together whenever the output slot is free or being drained.
  assign adv     = !s2_valid_q || i_ready;
  assign o_ready = adv;

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      assign s1_raw_d[k*OUTW +: OUTW] = i_data[k*INW +: OUTW];
      assign s1_neg_d[k]              = i_data[k*INW + INW - 1];

      // Any set magnitude bit above the output field means a positive value is too large.
      if (INW - 1 > OUTW) begin : g_ovf
        assign s1_ovf_d[k] = |i_data[k*INW + OUTW +: INW - 1 - OUTW];
      end else begin : g_no_ovf
        assign s1_ovf_d[k] = 1'b0;
      end

      // Negative or oversized inputs are out of range whichever mode the beat uses.
      assign s2_mask_d[k] = s1_neg_q[k] | s1_ovf_q[k];

      assign s2_data_d[k*OUTW +: OUTW] =
          s1_wrap_q   ? s1_raw_q[k*OUTW +: OUTW] :
          s1_neg_q[k] ? {OUTW{1'b0}} :
          s1_ovf_q[k] ? {OUTW{1'b1}} :
                        s1_raw_q[k*OUTW +: OUTW];
    end
  endgenerate

  // Pipeline registers: reset empties the pipe, a stall freezes both stages.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_wrap_q  <= 1'b0;
      s1_raw_q   <= '0;
      s1_neg_q   <= '0;
      s1_ovf_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mask_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= i_valid;
      s1_wrap_q  <= i_wrap;
      s1_raw_q   <= s1_raw_d;
      s1_neg_q   <= s1_neg_d;
      s1_ovf_q   <= s1_ovf_d;
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s2_data_d;
      s2_mask_q  <= s2_mask_d;
    end
  end

  assign o_valid   = s2_valid_q;
  assign o_data    = s2_data_q;
  assign o_satMask = s2_mask_q;

  assign sat_xfer = s2_valid_q && i_ready && (|s2_mask_q);

  // Counter next state: clear first, then a coinciding saturated transfer still counts once.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (i_clrCnt) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (sat_xfer) begin
      sticky_d = 1'b1;
      if (i_clrCnt) begin
        cnt_d = CNTW'(1);
      end else if (cnt_q != {CNTW{1'b1}}) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // Saturation counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign o_satCnt    = cnt_q;
  assign o_satSticky = sticky_q;

endmodule
